pps_interval_scheduler: RTL and testbench
=========================================

# pps_interval_scheduler

Multi-channel periodic event scheduler driven by the microsecond tick and PPS strobe derived from `clkIntervalCounters`. Each channel is programmed with a period in microseconds and emits a one-cycle trigger at that interval, phase-locked to the PPS edge. It sits between the interval counters and the event-generation logic, so one timebase is shared by all periodic requesters.

## Interface
- `NCHAN`, 4: number of independent channels (1–16).
- `PERIOD_WIDTH`, 20: period width in µs; max period 2^PERIOD_WIDTH−1.
- `clk`  in  1: system clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `usTick`  in  1: one-cycle strobe per microsecond.
- `ppsTick`  in  1: one-cycle strobe per second; coincides with a `usTick` cycle or stands alone.
- `cfgWrite`  in  1: one-cycle configuration write strobe.
- `cfgChannel`  in  $clog2(NCHAN): target channel of the write.
- `cfgEnable`  in  1: 1 = arm the channel with `cfgPeriod`; 0 = disable.
- `cfgPeriod`  in  PERIOD_WIDTH: period in µs; 0 is treated as disable.
- `trigger`  out  NCHAN: one-cycle event strobe per channel.
- `armed`  out  NCHAN: channel waiting for the next PPS.
- `running`  out  NCHAN: channel emitting triggers.

## Operation
- Per-channel states: IDLE, ARMED, RUNNING.
- Write with `cfgEnable`=1 and period≠0: latch period into shadow register; go ARMED from any state; no trigger until the next PPS.
- Write with `cfgEnable`=0 or period=0: go IDLE immediately; counter cleared; no trigger in the following cycle, even if one was due.
- ARMED + `ppsTick`: load active period from shadow; counter := period−1; fire trigger; go RUNNING.
- RUNNING + `usTick`: if counter=0, fire trigger and reload period−1; otherwise decrement.
- Period 1 fires on every `usTick`.
- `ppsTick` and `usTick` in the same cycle: PPS handling takes precedence; at most one trigger per channel per cycle.
- A write and a PPS to the same channel in the same cycle: the write wins, so the channel is ARMED with the new period and waits for the *next* PPS.
- Writes to an out-of-range `cfgChannel` (≥NCHAN) are ignored.
- Channels are fully independent; simultaneous triggers on several channels are allowed.

## Timing
- Reset values: `trigger`=0, `armed`=0, `running`=0; all channels IDLE; counters and periods 0.
- Trigger latency: 1 clock after the causing `ppsTick`/`usTick` cycle, from a registered output.
- `armed`/`running`: registered; they reflect the state 1 clock after the causing event.
- Config write takes effect the cycle after `cfgWrite`.
- Reset mid-operation: all channels return to IDLE on the next edge with `rst_n`=0; any pending trigger is dropped.
- Counter wrap is impossible, because reload occurs at 0.

## Configuration
- `PPS_RESYNC_EN` defined: every `ppsTick` re-phases RUNNING channels. The counter reloads to period−1 and a trigger fires, so periods that do not divide 1 s restart at each second.
- Undefined: PPS affects only ARMED channels. RUNNING channels free-run on `usTick` alone.

## Structure
- Shared package `pps_scheduler_pkg`:
  - channel-state enum (IDLE/ARMED/RUNNING)
  - default `NCHAN`/`PERIOD_WIDTH`
  - period-zero disable constant
- One sub-module `pps_scheduler_channel`: state machine, shadow/active period and down-counter for one channel; instantiated NCHAN times by generate.
- Top level decodes `cfgChannel` into per-channel write strobes.

## Test plan
- Reset, then ticks with no config → `trigger`, `armed`, `running` remain 0 for 3 PPS periods.
- Bench uses `usTick` every 10 clk and `ppsTick` every 1000 µs. Ch0 period 250 → `armed[0]`=1 until PPS; then triggers at PPS+1 clk and every 250 µs, i.e. 4 per second, aligned to PPS.
- Ch1 period 300, with `PPS_RESYNC_EN` defined → triggers at 0/300/600/900 µs, then at PPS (resync). Without the macro → free-run continues at 1200 µs with no PPS-aligned extra trigger.
- Write period 0 to RUNNING ch2 in the cycle before its due `usTick` → no trigger; `running[2]`=0 next clk.
- Write ch3 in the same cycle as `ppsTick` → ch3 stays ARMED; first trigger only at the following PPS.
- Assert `rst_n`=0 for 1 clk while all 4 channels are RUNNING → all outputs 0 the next clk; no triggers until reprogrammed and PPS.

Source files
------------

// File: rtl/pps_scheduler_pkg.sv
// Shared types and constants for the PPS-locked interval scheduler.
// Channel behaviour under PPS is selected by PPS_RESYNC_EN (see pps_scheduler_channel).
package pps_scheduler_pkg;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_ARMED   = 2'd1,
        CH_RUNNING = 2'd2
    } chan_state_t;

    localparam int unsigned DEF_NCHAN        = 4;
    localparam int unsigned DEF_PERIOD_WIDTH = 20;

    // A programmed period of this value disables the channel.
    localparam int unsigned PERIOD_DISABLE = 0;

    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pps_interval_scheduler_if.sv
// Tick, configuration and status bundle between the timebase/CPU side and the scheduler.
interface pps_interval_scheduler_if
    import pps_scheduler_pkg::*;
#(
    parameter int unsigned NCHAN        = DEF_NCHAN,
    parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH
);
    localparam int unsigned CHW = chan_w(NCHAN);

    logic                    usTick;
    logic                    ppsTick;
    logic                    cfgWrite;
    logic [CHW-1:0]          cfgChannel;
    logic                    cfgEnable;
    logic [PERIOD_WIDTH-1:0] cfgPeriod;
    logic [NCHAN-1:0]        trigger;
    logic [NCHAN-1:0]        armed;
    logic [NCHAN-1:0]        running;

    modport master (
        output usTick, ppsTick, cfgWrite, cfgChannel, cfgEnable, cfgPeriod,
        input  trigger, armed, running
    );

    modport slave (
        input  usTick, ppsTick, cfgWrite, cfgChannel, cfgEnable, cfgPeriod,
        output trigger, armed, running
    );

endinterface

// File: rtl/pps_scheduler_channel.sv
// One scheduler channel: IDLE/ARMED/RUNNING FSM, shadow/active period and down-counter.
// PPS_RESYNC_EN defined: each ppsTick re-phases RUNNING channels; otherwise they free-run.
module pps_scheduler_channel
    import pps_scheduler_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    usTick,
    input  logic                    ppsTick,
    input  logic                    wr,
    input  logic                    wrEnable,
    input  logic [PERIOD_WIDTH-1:0] wrPeriod,
    output logic                    trigger,
    output logic                    armed,
    output logic                    running
);
`ifdef PPS_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    localparam logic [PERIOD_WIDTH-1:0] ONE  = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] ZERO = PERIOD_WIDTH'(PERIOD_DISABLE);

    chan_state_t             state, state_nxt;
    logic [PERIOD_WIDTH-1:0] shadow, shadow_nxt;
    logic [PERIOD_WIDTH-1:0] active, active_nxt;
    logic [PERIOD_WIDTH-1:0] count, count_nxt;
    logic                    trig_q, trig_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= CH_IDLE;
            shadow <= '0;
            active <= '0;
            count  <= '0;
            trig_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            active <= active_nxt;
            count  <= count_nxt;
            trig_q <= trig_nxt;
        end
    end

    // A write outranks any tick in the same cycle, so it also suppresses a due trigger.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        active_nxt = active;
        count_nxt  = count;
        trig_nxt   = 1'b0;

        if (wr) begin
            count_nxt = '0;
            if (wrEnable && (wrPeriod != ZERO)) begin
                shadow_nxt = wrPeriod;
                state_nxt  = CH_ARMED;
            end else begin
                state_nxt  = CH_IDLE;
            end
        end else begin
            unique case (state)
                CH_ARMED: begin
                    if (ppsTick) begin
                        active_nxt = shadow;
                        count_nxt  = shadow - ONE;
                        trig_nxt   = 1'b1;
                        state_nxt  = CH_RUNNING;
                    end
                end
                CH_RUNNING: begin
                    if (RESYNC && ppsTick) begin
                        count_nxt = active - ONE;
                        trig_nxt  = 1'b1;
                    end else if (usTick) begin
                        if (count == '0) begin
                            count_nxt = active - ONE;
                            trig_nxt  = 1'b1;
                        end else begin
                            count_nxt = count - ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = CH_IDLE;
                end
            endcase
        end
    end

    assign trigger = trig_q;
    assign armed   = (state == CH_ARMED);
    assign running = (state == CH_RUNNING);

endmodule

// File: rtl/pps_interval_scheduler.sv
// Multi-channel PPS-phase-locked periodic trigger scheduler; decodes config writes per channel.
// Optional PPS_RESYNC_EN re-phases running channels on every PPS.
module pps_interval_scheduler
    import pps_scheduler_pkg::*;
#(
    parameter int unsigned NCHAN        = DEF_NCHAN,
    parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pps_interval_scheduler_if.slave  bus
);
    localparam int unsigned CHW = chan_w(NCHAN);

    logic [NCHAN-1:0] trig_v;
    logic [NCHAN-1:0] armed_v;
    logic [NCHAN-1:0] run_v;

    // Channel indices >= NCHAN match no instance, so such writes are dropped.
    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        logic wr;
        assign wr = bus.cfgWrite && (bus.cfgChannel == CHW'(i));

        pps_scheduler_channel #(
            .PERIOD_WIDTH (PERIOD_WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .usTick   (bus.usTick),
            .ppsTick  (bus.ppsTick),
            .wr       (wr),
            .wrEnable (bus.cfgEnable),
            .wrPeriod (bus.cfgPeriod),
            .trigger  (trig_v[i]),
            .armed    (armed_v[i]),
            .running  (run_v[i])
        );
    end

    assign bus.trigger = trig_v;
    assign bus.armed   = armed_v;
    assign bus.running = run_v;

endmodule

// File: tb/tb_pps_interval_scheduler.sv
// Directed bench for pps_interval_scheduler: usTick every 10 clk, ppsTick every 1000 us.
// Expectations follow PPS_RESYNC_EN when the macro is defined for the build.
module tb_pps_interval_scheduler;

`ifdef PPS_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pps_interval_scheduler_if #(.NCHAN(4), .PERIOD_WIDTH(20)) bus ();

    pps_interval_scheduler #(.NCHAN(4), .PERIOD_WIDTH(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int us_now  = 0;
    int trig_cnt [4];
    int last_trig[4];
    int status_hits = 0;
    int snap[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit us, input bit pps, input bit wr, input int ch,
                       input bit en, input int per);
        bus.usTick     = us;
        bus.ppsTick    = pps;
        bus.cfgWrite   = wr;
        bus.cfgChannel = 2'(ch);
        bus.cfgEnable  = en;
        bus.cfgPeriod  = 20'(per);
        @(posedge clk);
        #1;
        bus.usTick   = 1'b0;
        bus.ppsTick  = 1'b0;
        bus.cfgWrite = 1'b0;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic us_tick();
        cyc(1, (us_now % 1000) == 0, 0, 0, 0, 0);
    endtask

    task automatic run_us_to(input int target);
        while (us_now < target) begin
            us_tick();
            quiet(9);
            us_now++;
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (bus.trigger[c] === 1'b1) begin
                trig_cnt[c]++;
                last_trig[c] = us_now;
            end
        end
        if (bus.armed !== 4'b0 || bus.running !== 4'b0) status_hits++;
    end

    initial begin
        bus.usTick = 1'b0; bus.ppsTick = 1'b0; bus.cfgWrite = 1'b0;
        bus.cfgChannel = '0; bus.cfgEnable = 1'b0; bus.cfgPeriod = '0;
        rst_n = 1'b0;
        quiet(3);
        check("rst_trigger", bus.trigger, 0);
        check("rst_armed",   bus.armed,   0);
        check("rst_running", bus.running, 0);
        rst_n = 1'b1;

        // Three PPS strobes with nothing programmed.
        run_us_to(2001);
        check("idle_trigs", trig_cnt[0] + trig_cnt[1] + trig_cnt[2] + trig_cnt[3], 0);
        check("idle_status", status_hits, 0);

        cyc(0, 0, 1, 0, 1, 250);
        cyc(0, 0, 1, 1, 1, 300);
        cyc(0, 0, 1, 2, 1, 100);
        check("cfg_armed",   bus.armed,   4'b0111);
        check("cfg_running", bus.running, 4'b0000);

        run_us_to(3000);
        check("prepps_armed", bus.armed, 4'b0111);
        check("prepps_trigs", trig_cnt[0] + trig_cnt[1] + trig_cnt[2], 0);

        us_tick();
        check("pps3000_trigger", bus.trigger, 4'b0111);
        check("pps3000_running", bus.running, 4'b0111);
        check("pps3000_armed",   bus.armed,   4'b0000);
        quiet(1);
        check("pps3000_oneshot", bus.trigger, 4'b0000);
        quiet(8);
        us_now++;

        // Disable ch2 in the cycle right before its due usTick at 3100 us.
        run_us_to(3099);
        us_tick();
        quiet(8);
        cyc(0, 0, 1, 2, 1, 0);
        check("dis_running2", bus.running[2], 0);
        check("dis_trigger2", bus.trigger[2], 0);
        us_now++;
        us_tick();
        check("dis_due_trig2", bus.trigger[2], 0);
        quiet(9);
        us_now++;

        run_us_to(4000);
        check("cnt0_pre4000", trig_cnt[0], 4);
        check("cnt1_pre4000", trig_cnt[1], 4);
        check("cnt2_pre4000", trig_cnt[2], 1);

        // Write ch3 in the PPS cycle: it must stay armed until the next PPS.
        cyc(1, 1, 1, 3, 1, 500);
        check("pps4000_trigger", bus.trigger, RESYNC ? 4'b0011 : 4'b0001);
        check("pps4000_armed",   bus.armed,   4'b1000);
        check("pps4000_running", bus.running, 4'b0011);
        quiet(9);
        us_now++;

        run_us_to(4500);
        cyc(0, 0, 1, 2, 1, 100);
        run_us_to(5000);
        check("cnt0_pre5000",  trig_cnt[0], 8);
        check("cnt1_pre5000",  trig_cnt[1], RESYNC ? 8 : 7);
        check("last1_pre5000", last_trig[1], RESYNC ? 4900 : 4800);
        check("cnt3_pre5000",  trig_cnt[3], 0);
        check("armed_pre5000", bus.armed, 4'b1100);

        us_tick();
        check("pps5000_trigger", bus.trigger, RESYNC ? 4'b1111 : 4'b1101);
        check("pps5000_running", bus.running, 4'b1111);
        quiet(9);
        us_now++;

        // One-clock reset with all channels running.
        run_us_to(5010);
        rst_n = 1'b0;
        us_tick();
        check("midrst_trigger", bus.trigger, 0);
        check("midrst_armed",   bus.armed,   0);
        check("midrst_running", bus.running, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) snap[c] = trig_cnt[c];
        quiet(9);
        us_now++;

        cyc(0, 0, 1, 0, 1, 1);
        check("period1_armed", bus.armed, 4'b0001);
        run_us_to(6000);
        check("postrst_trigs", trig_cnt[0] + trig_cnt[1] + trig_cnt[2] + trig_cnt[3],
              snap[0] + snap[1] + snap[2] + snap[3]);
        us_tick();
        check("pps6000_trigger", bus.trigger, 4'b0001);
        quiet(9);
        us_now++;
        run_us_to(6010);
        check("period1_count", trig_cnt[0], snap[0] + 10);
        check("others_quiet", trig_cnt[1] + trig_cnt[2] + trig_cnt[3], snap[1] + snap[2] + snap[3]);

        cyc(0, 0, 1, 0, 0, 5);
        check("disable_running", bus.running, 0);
        check("disable_armed",   bus.armed,   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
